// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
  localparam int DIV_W   = 16;
  localparam int DIV_ITER = 16;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_16bit_seq_if.sv
// Start/busy/done handshake and operand/result bundle for div_16bit_seq.
interface div_16bit_seq_if
  import div_pkg::*;
;
  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/add_sub_16bit.sv
// Combinational 16-bit adder/subtractor; sel=1 computes in0-in1 with cout=1 meaning no borrow.
module add_sub_16bit (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        sel,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, in0} + {1'b0, in1 ^ {16{sel}}} + {16'b0, sel};
endmodule

// File: rtl/div_16bit_seq.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_SHORTCUT_EN: zero divisor publishes its result after one cycle.
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_RUN  | one restoring iteration per cycle, cnt 0..15
// ST_DONE | one-cycle done pulse; start here is accepted
module div_16bit_seq
  import div_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  div_16bit_seq_if.slave  bus
);
  div_state_e       state, state_nxt;
  logic [DIV_W-1:0] r_q, q_q, d_q;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic             rmsb, cout, ge, accept, last_iter, zero_short;
  logic [DIV_W-1:0] rs, sum, q_step, r_step;

  assign {rmsb, rs} = {r_q, q_q[DIV_W-1]};

  add_sub_16bit u_sub (
    .in0  (rs),
    .in1  (d_q),
    .sel  (1'b1),
    .sum  (sum),
    .cout (cout)
  );

  assign ge        = rmsb | cout;
  assign q_step    = {q_q[DIV_W-2:0], ge};
  assign r_step    = ge ? sum : rs;
  assign accept    = bus.start & (state != ST_RUN);
  assign last_iter = (cnt == CNT_W'(DIV_ITER - 1));

  // Shortcut takes its single RUN cycle so done lands one edge after acceptance.
`ifdef DIV_ZERO_SHORTCUT_EN
  assign zero_short = (d_q == '0);
`else
  assign zero_short = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last_iter || zero_short) state_nxt = ST_DONE;
      ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      ST_RUN:  bus.busy = 1'b1;
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt <= '0;
    end else if (accept) begin
      d_q <= bus.divisor;
      q_q <= bus.dividend;
      r_q <= '0;
      cnt <= '0;
    end else if (state == ST_RUN) begin
      q_q <= q_step;
      r_q <= r_step;
      cnt <= cnt + 1'b1;
    end
  end

  // Results are only ever written on the transition into ST_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (state == ST_RUN && zero_short) begin
      quotient_q  <= '1;
      remainder_q <= q_q;
      dbz_q       <= 1'b1;
    end else if (state == ST_RUN && last_iter) begin
      quotient_q  <= q_step;
      remainder_q <= r_step;
      dbz_q       <= (d_q == '0);
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
